udp_cmd_dispatcher: RTL
=======================

// Module: udp_cmd_dispatcher
// PURPOSE
//  Sequences UDP payload bytes into a bank of NUM_CH per-channel byte readers.
//  Parses a 2-byte header, channel id then payload length.
//  Clears the selected reader, then forwards the payload bytes to it.
//  Checks the payload length against rx_eop and reports per-packet done or error.
//  Sits between the UDP RX depacketiser and the reader bank.
// PARAMETERS
//  NUM_CH   4    number of downstream readers; ch_* vectors are NUM_CH wide
//  MAX_LEN  16   largest legal payload length in bytes (1..255)
// PORTS
//  clk       in   1        clock clk
//  rstn      in   1        reset rstn, asynchronous, active-low
//  rx_valid  in   1        rx_data/rx_sop/rx_eop qualify this cycle
//  rx_data   in   8        payload byte
//  rx_sop    in   1        first byte of the UDP payload (valid-qualified)
//  rx_eop    in   1        last byte of the UDP payload (valid-qualified)
//  ch_valid  out  NUM_CH   one-hot byte strobe to the selected reader
//  ch_data   out  8        byte to the readers (shared bus)
//  ch_rstn   out  NUM_CH   per-reader clear, active-low, one-cycle pulse
//  busy      out  1        packet in progress (state != IDLE)
//  pkt_done  out  1        one-cycle pulse: packet accepted without error
//  pkt_err   out  1        one-cycle pulse: packet rejected
//  err_code  out  3        0 BAD_CH, 1 BAD_LEN, 2 SHORT, 3 LONG, 4 CSUM; held until next pkt_err
// BEHAVIOUR
//  Reset values:
//   - ch_valid=0, ch_data=0, ch_rstn=all 1s, busy=0, pkt_done=0, pkt_err=0, err_code=0.
//   - state=IDLE; internal id/len/count=0.
//  Output timing:
//   - All outputs are registered.
//   - A forwarded byte appears on ch_data/ch_valid 1 cycle after its rx_valid cycle.
//  Input handling:
//   - Bytes with rx_valid=0 are ignored, including their sop/eop.
//   - No backpressure: one byte per cycle is always accepted.
//  FSM states: IDLE, HDR_LEN, PAYLOAD, CSUM, DRAIN.
//  IDLE:
//   - Byte with rx_sop latches id.
//   - Byte without rx_sop is dropped silently.
//  IDLE -> HDR_LEN:
//   - Taken when id < NUM_CH.
//   - Otherwise pkt_err with BAD_CH; go to DRAIN (or IDLE if rx_eop on that byte).
//  HDR_LEN:
//   - Next byte latches len.
//   - len==0 or len>MAX_LEN: pkt_err BAD_LEN, then DRAIN.
//   - Else: ch_rstn[id]=0 for 1 cycle, count=0, go to PAYLOAD.
//   - No payload byte forwards in the ch_rstn cycle, because the header byte is not forwarded.
//  PAYLOAD:
//   - Each byte is forwarded on ch_valid[id]; count increments (8-bit).
//   - Byte with count==len-1 and rx_eop: pkt_done, go to IDLE.
//   - Byte with count==len-1 and no rx_eop: pkt_err LONG, go to DRAIN. The last byte is still forwarded.
//   - rx_eop with count<len-1: pkt_err SHORT, go to IDLE. That byte is forwarded.
//  DRAIN:
//   - Bytes are dropped; rx_eop returns to IDLE.
//   - No further done/err pulses are raised.
//  rx_eop on the header:
//   - rx_eop on the id byte (sop and eop on the same byte): pkt_err SHORT.
//   - rx_eop on the len byte: pkt_err SHORT.
//  rx_sop when not in IDLE:
//   - The current packet is abandoned and this byte is parsed as a new id.
//   - pkt_err SHORT is pulsed in the same cycle if the packet was in HDR_LEN, PAYLOAD or CSUM.
//   - No pulse if the packet was in DRAIN.
//  General:
//   - pkt_done and pkt_err are never asserted together.
//   - At most one pkt_done/pkt_err pulse is raised per packet.
//   - Reset mid-packet: immediate return to IDLE; no pulse; ch_rstn is not pulsed.
// CONFIGURATION
//  UDP_DISPATCH_CSUM_EN defined:
//   - After len payload bytes, one checksum byte follows: XOR of id, len and all payload bytes.
//   - The checksum byte is not forwarded.
//   - PAYLOAD goes to CSUM on count==len-1 (eop there gives SHORT).
//   - In CSUM, rx_eop with a matching checksum: pkt_done.
//   - In CSUM, rx_eop with a mismatching checksum: pkt_err CSUM (4).
//   - In CSUM, no rx_eop: pkt_err LONG, then DRAIN.
//  UDP_DISPATCH_CSUM_EN undefined:
//   - No CSUM state; code 4 is never produced.
//   - The packet ends on the len-th payload byte.
// TESTING (NUM_CH=4, MAX_LEN=16, macro off unless noted)
//  sop 02, 03, AA, BB, CC+eop
//   -> ch_rstn[2] low 1 cycle, then ch_valid=0100 with AA, BB, CC on consecutive cycles.
//   -> pkt_done 1 cycle after the CC byte.
//  sop 05, 01, 11+eop -> pkt_err, err_code=0; no ch_valid; busy low after eop.
//  sop 01, 00, ..eop -> BAD_LEN; sop 01, 11 (len 17) -> BAD_LEN.
//  sop 00, 04, A1, A2+eop -> SHORT; A1 and A2 are forwarded to ch 0.
//  sop 00, 02, A1, A2, A3, A4+eop -> LONG after A2; A3 and A4 are dropped.
//  sop mid-payload -> SHORT pulse; the new packet completes normally.
//  Macro on: sop 01, 02, 10, 20, 33+eop -> pkt_done (01^02^10^20=33); checksum 34 -> err_code=4.
//  Async rstn pulse mid-payload -> all outputs at reset values; the next packet parses normally.

Source files
------------

// File: rtl/udp_cmd_dispatcher.sv
// udp_cmd_dispatcher
//   Splits a UDP payload stream into per-channel byte streams. Each packet carries a
//   channel id byte and a length byte, then the payload. The selected reader is cleared
//   with a one-cycle ch_rstn_o pulse, then the payload bytes are forwarded to it. The
//   payload length is checked against rx_eop_i and one done/err pulse is reported per
//   packet.
//
//   Optional feature: define UDP_DISPATCH_CSUM_EN to expect one trailing checksum byte
//   (XOR of id, len and payload). It is checked and not forwarded.
//
// Ports
//   clk         clock
//   rstn        asynchronous active-low reset
//   rx_valid_i  qualifies rx_data_i / rx_sop_i / rx_eop_i
//   rx_data_i   payload byte
//   rx_sop_i    first byte of the UDP payload
//   rx_eop_i    last byte of the UDP payload
//   ch_valid_o  one-hot byte strobe to the selected reader
//   ch_data_o   byte to the readers (shared bus)
//   ch_rstn_o   per-reader clear, active-low, one-cycle pulse
//   busy_o      packet in progress
//   pkt_done_o  one-cycle pulse, packet accepted
//   pkt_err_o   one-cycle pulse, packet rejected
//   err_code_o  0 BAD_CH, 1 BAD_LEN, 2 SHORT, 3 LONG, 4 CSUM; held until next error
module udp_cmd_dispatcher #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned MAX_LEN = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              rx_valid_i,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_sop_i,
   input  logic              rx_eop_i,
   output logic [NUM_CH-1:0] ch_valid_o,
   output logic [7:0]        ch_data_o,
   output logic [NUM_CH-1:0] ch_rstn_o,
   output logic              busy_o,
   output logic              pkt_done_o,
   output logic              pkt_err_o,
   output logic [2:0]        err_code_o
);

   localparam logic [7:0] NumCh  = 8'(NUM_CH);
   localparam logic [7:0] MaxLen = 8'(MAX_LEN);

   localparam logic [2:0] ErrBadCh  = 3'd0;
   localparam logic [2:0] ErrBadLen = 3'd1;
   localparam logic [2:0] ErrShort  = 3'd2;
   localparam logic [2:0] ErrLong   = 3'd3;
`ifdef UDP_DISPATCH_CSUM_EN
   localparam logic [2:0] ErrCsum   = 3'd4;
`endif

   typedef enum logic [2:0] {
      StIdle,
      StHdrLen,
      StPayload,
      StDrain
`ifdef UDP_DISPATCH_CSUM_EN
      , StCsum
`endif
   } state_e;

   state_e state_q, state_d;
   logic [7:0] id_q, id_d;
   logic [7:0] len_q, len_d;
   logic [7:0] cnt_q, cnt_d;
`ifdef UDP_DISPATCH_CSUM_EN
   logic [7:0] csum_q, csum_d;
`endif

   logic [NUM_CH-1:0] ch_valid_q, ch_valid_d;
   logic [7:0]        ch_data_q, ch_data_d;
   logic [NUM_CH-1:0] ch_rstn_q, ch_rstn_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [2:0]        code_q, code_d;

   // Packet still owes a done/err report when it is cut short by a new sop.
   logic abandon;

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
`ifdef UDP_DISPATCH_CSUM_EN
      csum_d     = csum_q;
`endif
      ch_valid_d = '0;
      ch_data_d  = ch_data_q;
      ch_rstn_d  = '1;
      done_d     = 1'b0;
      err_d      = 1'b0;
      code_d     = code_q;
      abandon    = 1'b0;

      if (rx_valid_i) begin
         if (rx_sop_i) begin
            abandon = (state_q == StHdrLen) || (state_q == StPayload)
`ifdef UDP_DISPATCH_CSUM_EN
                      || (state_q == StCsum)
`endif
                      ;
            id_d = rx_data_i;
`ifdef UDP_DISPATCH_CSUM_EN
            csum_d = rx_data_i;
`endif
            if (rx_data_i >= NumCh) begin
               err_d   = 1'b1;
               code_d  = ErrBadCh;
               state_d = rx_eop_i ? StIdle : StDrain;
            end else if (rx_eop_i) begin
               err_d   = 1'b1;
               code_d  = ErrShort;
               state_d = StIdle;
            end else begin
               state_d = StHdrLen;
            end
            // The abandoned packet's report takes precedence over the new id's.
            if (abandon) begin
               err_d  = 1'b1;
               code_d = ErrShort;
            end
         end else begin
            unique case (state_q)
               StIdle: begin
                  // Bytes outside a packet are dropped.
               end
               StHdrLen: begin
                  len_d = rx_data_i;
`ifdef UDP_DISPATCH_CSUM_EN
                  csum_d = csum_q ^ rx_data_i;
`endif
                  if ((rx_data_i == 8'd0) || (rx_data_i > MaxLen)) begin
                     err_d   = 1'b1;
                     code_d  = ErrBadLen;
                     state_d = rx_eop_i ? StIdle : StDrain;
                  end else if (rx_eop_i) begin
                     err_d   = 1'b1;
                     code_d  = ErrShort;
                     state_d = StIdle;
                  end else begin
                     for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (id_q == 8'(i)) begin
                           ch_rstn_d[i] = 1'b0;
                        end
                     end
                     cnt_d   = 8'd0;
                     state_d = StPayload;
                  end
               end
               StPayload: begin
                  for (int unsigned i = 0; i < NUM_CH; i++) begin
                     if (id_q == 8'(i)) begin
                        ch_valid_d[i] = 1'b1;
                     end
                  end
                  ch_data_d = rx_data_i;
                  cnt_d     = cnt_q + 8'd1;
`ifdef UDP_DISPATCH_CSUM_EN
                  csum_d = csum_q ^ rx_data_i;
`endif
                  if (cnt_q == len_q - 8'd1) begin
`ifdef UDP_DISPATCH_CSUM_EN
                     // Checksum byte must still follow.
                     if (rx_eop_i) begin
                        err_d   = 1'b1;
                        code_d  = ErrShort;
                        state_d = StIdle;
                     end else begin
                        state_d = StCsum;
                     end
`else
                     if (rx_eop_i) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                     end else begin
                        err_d   = 1'b1;
                        code_d  = ErrLong;
                        state_d = StDrain;
                     end
`endif
                  end else if (rx_eop_i) begin
                     err_d   = 1'b1;
                     code_d  = ErrShort;
                     state_d = StIdle;
                  end
               end
`ifdef UDP_DISPATCH_CSUM_EN
               StCsum: begin
                  if (rx_eop_i) begin
                     if (rx_data_i == csum_q) begin
                        done_d = 1'b1;
                     end else begin
                        err_d  = 1'b1;
                        code_d = ErrCsum;
                     end
                     state_d = StIdle;
                  end else begin
                     err_d   = 1'b1;
                     code_d  = ErrLong;
                     state_d = StDrain;
                  end
               end
`endif
               StDrain: begin
                  if (rx_eop_i) begin
                     state_d = StIdle;
                  end
               end
               default: begin
                  state_d = StIdle;
               end
            endcase
         end
      end

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         id_q       <= 8'd0;
         len_q      <= 8'd0;
         cnt_q      <= 8'd0;
`ifdef UDP_DISPATCH_CSUM_EN
         csum_q     <= 8'd0;
`endif
         ch_valid_q <= '0;
         ch_data_q  <= 8'd0;
         ch_rstn_q  <= '1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         code_q     <= 3'd0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
`ifdef UDP_DISPATCH_CSUM_EN
         csum_q     <= csum_d;
`endif
         ch_valid_q <= ch_valid_d;
         ch_data_q  <= ch_data_d;
         ch_rstn_q  <= ch_rstn_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         code_q     <= code_d;
      end
   end

   assign ch_valid_o = ch_valid_q;
   assign ch_data_o  = ch_data_q;
   assign ch_rstn_o  = ch_rstn_q;
   assign busy_o     = busy_q;
   assign pkt_done_o = done_q;
   assign pkt_err_o  = err_q;
   assign err_code_o = code_q;

endmodule
